// File: rtl/sr_piso_tx_4bit.sv
// ---------------------------------------------------------------------------
// sr_piso_tx_4bit
// Parallel-in, serial-out framed transmitter. A WIDTH-bit word is accepted
// over a valid/ready handshake and sent on one serial line as:
//   start bit (1), data LSB-first, optional even-parity bit, stop bit (0).
// Every serial bit is held for CLK_DIV clock cycles. The idle line level is 0.
//
// Parameters:
//   WIDTH      data word width in bits (>=1)
//   CLK_DIV    clock cycles per serial bit (>=1)
//   PARITY_EN  1 inserts an even-parity bit after the data bits
//
// Ports:
//   i_clk        clock, all state updates on the rising edge
//   i_rst_n      asynchronous active-low reset
//   i_din        parallel word to transmit
//   i_din_valid  i_din holds a word to send
//   o_din_ready  block can accept a word this cycle (high only in IDLE)
//   o_sout       registered serial line
//   o_busy       frame in progress (START through STOP)
//   o_done       one-cycle pulse in the last clock of the stop bit
// ---------------------------------------------------------------------------
module sr_piso_tx_4bit #(
    parameter int WIDTH     = 4,
    parameter int CLK_DIV   = 1,
    parameter int PARITY_EN = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_din_valid,
    output logic             o_din_ready,
    output logic             o_sout,
    output logic             o_busy,
    output logic             o_done
);

    // A divide-by-one needs no real counter, but a zero-width vector is
    // illegal, so the divider is always at least one bit wide.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [WIDTH-1:0] r_shiftReg;
    logic [WIDTH-1:0] w_shiftRegNext;
    logic [CNT_W-1:0] r_bitCnt;
    logic [CNT_W-1:0] w_bitCntNext;
    logic [DIV_W-1:0] r_divCnt;
    logic [DIV_W-1:0] w_divCntNext;
    logic             r_parity;
    logic             w_parityNext;
    logic             r_sout;
    logic             w_soutNext;
    logic             w_tick;
    logic             w_accept;

    // A bit period ends when the divider reaches its last count.
    assign w_tick      = (r_divCnt == DIV_LAST);
    assign o_din_ready = (r_state == IDLE);
    assign w_accept    = i_din_valid && o_din_ready;
    assign o_busy      = (r_state != IDLE);
    assign o_done      = (r_state == STOP) && w_tick;
    assign o_sout      = r_sout;

    // State register and datapath registers. The serial line is registered
    // from the value belonging to the next state, so the line level always
    // lines up with the state currently held in r_state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_shiftReg <= '0;
            r_bitCnt   <= '0;
            r_divCnt   <= '0;
            r_parity   <= 1'b0;
            r_sout     <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_shiftReg <= w_shiftRegNext;
            r_bitCnt   <= w_bitCntNext;
            r_divCnt   <= w_divCntNext;
            r_parity   <= w_parityNext;
            r_sout     <= w_soutNext;
        end
    end

    // Next-state and datapath logic. The divider is cleared on every state
    // change and also wraps at the end of each data bit while staying in
    // DATA; in IDLE it is held at zero so a new frame starts cleanly.
    always_comb begin
        w_stateNext    = r_state;
        w_shiftRegNext = r_shiftReg;
        w_bitCntNext   = r_bitCnt;
        w_parityNext   = r_parity;
        w_divCntNext   = w_tick ? '0 : r_divCnt + DIV_W'(1);
        w_soutNext     = 1'b0;

        case (r_state)
            IDLE: begin
                w_divCntNext = '0;
                w_bitCntNext = '0;
                if (w_accept) begin
                    w_stateNext    = START;
                    w_shiftRegNext = i_din;
                    w_parityNext   = ^i_din;
                end
            end
            START: begin
                if (w_tick) begin
                    w_stateNext = DATA;
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_shiftRegNext = r_shiftReg >> 1;
                    if (r_bitCnt == BIT_LAST) begin
                        w_bitCntNext = '0;
                        w_stateNext  = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        w_bitCntNext = r_bitCnt + CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (w_tick) begin
                    w_stateNext = STOP;
                end
            end
            STOP: begin
                if (w_tick) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase

        // Line level for the state being entered (or kept).
        case (w_stateNext)
            START:   w_soutNext = 1'b1;
            DATA:    w_soutNext = w_shiftRegNext[0];
            PARITY:  w_soutNext = w_parityNext;
            default: w_soutNext = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_sr_piso_tx_4bit.sv
// ---------------------------------------------------------------------------
// tb_sr_piso_tx_4bit
// Three transmitter instances share clock and reset:
//   u0: WIDTH=4 CLK_DIV=1 PARITY_EN=0
//   u1: WIDTH=4 CLK_DIV=1 PARITY_EN=1
//   u2: WIDTH=4 CLK_DIV=3 PARITY_EN=0
// Expected per-cycle {sout,busy,done,ready} values are built from the frame
// format and queued when a word is driven, then popped each cycle.
// ---------------------------------------------------------------------------
module tb_sr_piso_tx_4bit;

    typedef struct packed {
        logic sout;
        logic busy;
        logic done;
        logic ready;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] din [3];
    logic [2:0] valid;
    wire  [2:0] ready;
    wire  [2:0] sout;
    wire  [2:0] busy;
    wire  [2:0] done;

    exp_t expQ[$];
    int   passCount;
    int   checkCount;

    sr_piso_tx_4bit #(.WIDTH(4), .CLK_DIV(1), .PARITY_EN(0)) u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_din(din[0]), .i_din_valid(valid[0]),
        .o_din_ready(ready[0]), .o_sout(sout[0]), .o_busy(busy[0]), .o_done(done[0])
    );

    sr_piso_tx_4bit #(.WIDTH(4), .CLK_DIV(1), .PARITY_EN(1)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_din(din[1]), .i_din_valid(valid[1]),
        .o_din_ready(ready[1]), .o_sout(sout[1]), .o_busy(busy[1]), .o_done(done[1])
    );

    sr_piso_tx_4bit #(.WIDTH(4), .CLK_DIV(3), .PARITY_EN(0)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_din(din[2]), .i_din_valid(valid[2]),
        .o_din_ready(ready[2]), .o_sout(sout[2]), .o_busy(busy[2]), .o_done(done[2])
    );

    // Free-running 100 MHz clock, rising edges at 5, 15, 25 ns ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue the expected line/flag values of one full frame.
    task automatic pushFrame(input logic [3:0] word, input int div, input bit par);
        logic bits [$];
        bits.push_back(1'b1);
        for (int b = 0; b < 4; b++) bits.push_back(word[b]);
        if (par) bits.push_back(^word);
        bits.push_back(1'b0);
        for (int b = 0; b < bits.size(); b++) begin
            for (int c = 0; c < div; c++) begin
                expQ.push_back({bits[b], 1'b1,
                                (b == bits.size() - 1) && (c == div - 1), 1'b0});
            end
        end
    endtask

    // Queue one idle cycle between or after frames.
    task automatic pushIdle();
        expQ.push_back(4'b0001);
    endtask

    task automatic test_reset();
        exp_t obs;
        rst_n = 1'b0;
        valid = 3'b000;
        for (int k = 0; k < 3; k++) din[k] = 4'h0;
        #3;
        for (int k = 0; k < 3; k++) begin
            obs = {sout[k], busy[k], done[k], ready[k]};
            checkCount++;
            if (obs !== 4'b0001)
                $display("[TB] FAIL reset_hold u%0d: got %b expected 0001", k, obs);
            else passCount++;
        end
        #7;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                obs = {sout[k], busy[k], done[k], ready[k]};
                checkCount++;
                if (obs !== 4'b0001)
                    $display("[TB] FAIL reset_idle u%0d cyc %0d: got %b expected 0001", k, i, obs);
                else passCount++;
            end
        end
    endtask

    task automatic test_single_frame();
        exp_t obs;
        exp_t e;
        int   i;
        din[0]   = 4'b1011;
        valid[0] = 1'b1;
        pushFrame(4'b1011, 1, 1'b0);
        pushIdle();
        @(negedge clk);
        valid[0] = 1'b0;
        din[0]   = 4'b0000;
        i = 0;
        while (expQ.size() > 0) begin
            e   = expQ.pop_front();
            obs = {sout[0], busy[0], done[0], ready[0]};
            checkCount++;
            if (obs !== e)
                $display("[TB] FAIL single_frame cyc %0d: got sout/busy/done/ready=%b expected %b", i, obs, e);
            else passCount++;
            i++;
            @(negedge clk);
        end
    endtask

    task automatic test_parity(input logic [3:0] word);
        exp_t obs;
        exp_t e;
        int   i;
        din[1]   = word;
        valid[1] = 1'b1;
        pushFrame(word, 1, 1'b1);
        pushIdle();
        @(negedge clk);
        valid[1] = 1'b0;
        i = 0;
        while (expQ.size() > 0) begin
            e   = expQ.pop_front();
            obs = {sout[1], busy[1], done[1], ready[1]};
            checkCount++;
            if (obs !== e)
                $display("[TB] FAIL parity_%b cyc %0d: got %b expected %b", word, i, obs, e);
            else passCount++;
            i++;
            @(negedge clk);
        end
    endtask

    task automatic test_bit_period();
        exp_t obs;
        exp_t e;
        int   i;
        din[2]   = 4'b0101;
        valid[2] = 1'b1;
        pushFrame(4'b0101, 3, 1'b0);
        pushIdle();
        @(negedge clk);
        valid[2] = 1'b0;
        i = 0;
        while (expQ.size() > 0) begin
            e   = expQ.pop_front();
            obs = {sout[2], busy[2], done[2], ready[2]};
            checkCount++;
            if (obs !== e)
                $display("[TB] FAIL bit_period cyc %0d: got %b expected %b", i, obs, e);
            else passCount++;
            i++;
            @(negedge clk);
        end
    endtask

    // din_valid stays high across two frames; din is disturbed during the
    // first frame and only settles to the second word before it is taken.
    task automatic test_back_to_back();
        exp_t obs;
        exp_t e;
        int   i;
        din[0]   = 4'hA;
        valid[0] = 1'b1;
        pushFrame(4'hA, 1, 1'b0);
        pushIdle();
        pushFrame(4'h5, 1, 1'b0);
        pushIdle();
        @(negedge clk);
        i = 0;
        while (expQ.size() > 0) begin
            e   = expQ.pop_front();
            obs = {sout[0], busy[0], done[0], ready[0]};
            checkCount++;
            if (obs !== e)
                $display("[TB] FAIL back_to_back cyc %0d: got %b expected %b", i, obs, e);
            else passCount++;
            if (i == 1) din[0] = 4'hC;
            if (i == 3) din[0] = 4'h5;
            if (i == 7) valid[0] = 1'b0;
            i++;
            @(negedge clk);
        end
    endtask

    // A new word offered while a frame is in flight must not be captured.
    task automatic test_busy_ignore();
        exp_t obs;
        exp_t e;
        int   i;
        din[1]   = 4'b0110;
        valid[1] = 1'b1;
        pushFrame(4'b0110, 1, 1'b1);
        pushIdle();
        @(negedge clk);
        valid[1] = 1'b0;
        i = 0;
        while (expQ.size() > 0) begin
            e   = expQ.pop_front();
            obs = {sout[1], busy[1], done[1], ready[1]};
            checkCount++;
            if (obs !== e)
                $display("[TB] FAIL busy_ignore cyc %0d: got %b expected %b", i, obs, e);
            else passCount++;
            if (i == 2) begin
                din[1]   = 4'b1111;
                valid[1] = 1'b1;
            end
            if (i == 4) valid[1] = 1'b0;
            i++;
            @(negedge clk);
        end
    endtask

    task automatic test_mid_reset();
        exp_t obs;
        exp_t e;
        int   i;
        din[0]   = 4'hF;
        valid[0] = 1'b1;
        pushFrame(4'hF, 1, 1'b0);
        @(negedge clk);
        valid[0] = 1'b0;
        // start bit, data bits 0 and 1, then the third data bit
        for (int j = 0; j < 4; j++) begin
            e   = expQ.pop_front();
            obs = {sout[0], busy[0], done[0], ready[0]};
            checkCount++;
            if (obs !== e)
                $display("[TB] FAIL mid_reset_pre cyc %0d: got %b expected %b", j, obs, e);
            else passCount++;
            if (j < 3) @(negedge clk);
        end
        expQ.delete();
        #2 rst_n = 1'b0;
        #1;
        obs = {sout[0], busy[0], done[0], ready[0]};
        checkCount++;
        if (obs !== 4'b0001)
            $display("[TB] FAIL mid_reset_async: got %b expected 0001", obs);
        else passCount++;
        @(negedge clk);
        obs = {sout[0], busy[0], done[0], ready[0]};
        checkCount++;
        if (obs !== 4'b0001)
            $display("[TB] FAIL mid_reset_hold: got %b expected 0001", obs);
        else passCount++;
        rst_n    = 1'b1;
        din[0]   = 4'h1;
        valid[0] = 1'b1;
        pushFrame(4'h1, 1, 1'b0);
        pushIdle();
        @(negedge clk);
        valid[0] = 1'b0;
        i = 0;
        while (expQ.size() > 0) begin
            e   = expQ.pop_front();
            obs = {sout[0], busy[0], done[0], ready[0]};
            checkCount++;
            if (obs !== e)
                $display("[TB] FAIL mid_reset_post cyc %0d: got %b expected %b", i, obs, e);
            else passCount++;
            i++;
            @(negedge clk);
        end
    endtask

    // Run every scenario in order and report.
    initial begin
        passCount  = 0;
        checkCount = 0;
        test_reset();
        test_single_frame();
        test_parity(4'b1011);
        test_parity(4'b0110);
        test_bit_period();
        test_back_to_back();
        test_busy_ignore();
        test_mid_reset();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
